rv32i_bus_bridge: RTL and testbench
===================================

RV32I_BUS_BRIDGE -- requirements
Module: rv32i_bus_bridge

Interface
REQ-001 SHALL have parameter ROM_BASE, default 32'h0040_0000, meaning instruction ROM base address.
REQ-002 SHALL have parameter RAM_BASE, default 32'h1001_0000, meaning data RAM base address.
REQ-003 SHALL have parameter IO_BASE, default 32'h1002_4000, meaning GPIO register page base address.
REQ-004 SHALL have parameter MEM_SIZE_LOG2, default 12, meaning ROM and RAM region size in bytes, log2.
REQ-005 SHALL have parameters ROM_WAIT and RAM_WAIT, default 1, meaning wait cycles per access, legal range 0..7.
REQ-006 SHALL have port clk  in  1  the single clock; all state changes on its rising edge.
REQ-007 SHALL have port rst  in  1  reset; asynchronous, active-low.
REQ-008 SHALL have ports bus_addr  in  32, bus_wrdata  in  32, bus_wren  in  1, bus_rden  in  1: the core request.
REQ-009 SHALL have ports bus_rddata  out  32, bus_ready  out  1, bus_err  out  1: the core response.
REQ-010 SHALL have ports rom_addr  out  MEM_SIZE_LOG2-2, rom_rddata  in  32: the ROM word port.
REQ-011 SHALL have ports ram_addr  out  MEM_SIZE_LOG2-2, ram_wrdata  out  32, ram_we  out  1, ram_rddata  in  32: the RAM word port.
REQ-012 SHALL have ports gpio_out  out  32 and gpio_in  in  32 (asynchronous input).

Function
REQ-013 SHALL use FSM states IDLE, WAIT, RESP; one outstanding request at a time.
REQ-014 SHALL accept a request only in IDLE when bus_rden or bus_wren is 1, latching addr, wrdata and op on that edge; requests outside IDLE are ignored.
REQ-015 SHALL decode a region by comparing addr[31:MEM_SIZE_LOG2] with the matching base bits; the word index is addr[MEM_SIZE_LOG2-1:2].
REQ-016 SHALL flag an error when: both bus_rden and bus_wren are 1; addr[1:0] is nonzero; the address is unmapped; the request writes ROM; or the IO offset is neither 0 nor 4.
REQ-017 SHALL, for an error, go IDLE->RESP with bus_ready=1, bus_err=1 and bus_rddata=0 for one cycle, with no ROM, RAM or GPIO side effect.
REQ-018 SHALL, for a ROM/RAM access, go IDLE->WAIT with a 3-bit counter loaded with the region wait, decrementing each WAIT cycle; on count 0 it captures rom_rddata/ram_rddata into bus_rddata and goes to RESP.
REQ-019 SHALL drive rom_addr/ram_addr from the latched address throughout WAIT; the memories are synchronous with data valid one cycle after the address.
REQ-020 SHALL pulse ram_we for exactly the first WAIT cycle of a RAM write, with ram_wrdata equal to the latched data.
REQ-021 SHALL, for an IO access, go IDLE->RESP directly: a write at offset 0 loads gpio_out; a read at offset 0 returns gpio_out; a read at offset 4 returns gpio_in through a 2-flop synchronizer.
REQ-022 SHALL assert bus_ready for exactly one cycle in RESP, then return to IDLE; latency from the accept edge is 1+WAIT+1 cycles for ROM/RAM and 1 cycle for IO and errors.
REQ-023 SHALL hold bus_rddata at its last read value; a write completion drives 0 in its RESP cycle and the held value is cleared.
REQ-024 SHALL accept a new request in the IDLE cycle after RESP; back-to-back requests are never merged.

Reset
REQ-025 SHALL, while rst=0, force state IDLE, counter 0, bus_ready=0, bus_err=0, bus_rddata=0, ram_we=0, gpio_out=0, addresses 0 and synchronizer flops 0, regardless of the clock.
REQ-026 SHALL abandon any in-flight request on reset without issuing ram_we, and SHALL accept requests from the first rising edge after rst returns to 1.

Verification
REQ-027 SHALL cover: RAM write 0xDEADBEEF to 0x1001_0010, then read it back -> ram_we for 1 cycle at ram_addr 4; the read returns 0xDEADBEEF with bus_ready 3 cycles after accept.
REQ-028 SHALL cover: ROM read at 0x0040_0000 with ROM_WAIT=0 -> bus_ready 2 cycles after accept with rddata = rom_rddata.
REQ-029 SHALL cover: error cases -- write to 0x0040_0004, read of 0x1001_0002, read of 0x2000_0000, rden&wren together -> each gives bus_ready=bus_err=1 one cycle after accept, no ram_we, gpio_out unchanged.
REQ-030 SHALL cover: GPIO -- write 0xA5 to IO_BASE, then read IO_BASE -> 0x000000A5; with gpio_in=0x1234, a read of IO_BASE+4 -> 0x1234 at least 2 cycles after gpio_in settles.
REQ-031 SHALL cover: reset asserted during the WAIT of a RAM write -> no ram_we, outputs 0 immediately, next request serviced normally.
REQ-032 SHALL cover: a request held high through RESP -> serviced exactly twice, with an IDLE cycle between.

Source files
------------

// File: rtl/rv32i_bus_bridge.sv
// Purpose : single-outstanding bridge from an RV32I core data/instr bus to a
//           ROM word port, a RAM word port and a two-register GPIO page.
// Latency : ROM/RAM 1+WAIT+1 cycles from accept; GPIO and errors 1 cycle.
// Backpr. : requests are accepted only in IDLE; anything presented while busy
//           is ignored, so the core must hold its request until bus_ready.
// Ports   : clk/rst (async active-low); bus_* core request/response;
//           rom_* / ram_* synchronous word-addressed memories (data one cycle
//           after address); gpio_out register, gpio_in asynchronous input.
module rv32i_bus_bridge #(
  parameter logic [31:0] ROM_BASE      = 32'h0040_0000,
  parameter logic [31:0] RAM_BASE      = 32'h1001_0000,
  parameter logic [31:0] IO_BASE       = 32'h1002_4000,
  parameter int unsigned MEM_SIZE_LOG2 = 12,
  parameter int unsigned ROM_WAIT      = 1,   // 0..7
  parameter int unsigned RAM_WAIT      = 1    // 0..7
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              bus_addr,
  input  logic [31:0]              bus_wrdata,
  input  logic                     bus_wren,
  input  logic                     bus_rden,
  output logic [31:0]              bus_rddata,
  output logic                     bus_ready,
  output logic                     bus_err,
  output logic [MEM_SIZE_LOG2-3:0] rom_addr,
  input  logic [31:0]              rom_rddata,
  output logic [MEM_SIZE_LOG2-3:0] ram_addr,
  output logic [31:0]              ram_wrdata,
  output logic                     ram_we,
  input  logic [31:0]              ram_rddata,
  output logic [31:0]              gpio_out,
  input  logic [31:0]              gpio_in
);

  localparam int unsigned AW = MEM_SIZE_LOG2 - 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [2:0]  r_cnt;
  logic [AW-1:0] r_idx;
  logic [31:0] r_wrdata;
  logic        r_is_wr;
  logic        r_is_ram;
  logic        r_err;
  logic        r_ram_we;
  logic [31:0] r_rddata;
  logic [31:0] r_gpio_out;
  logic [31:0] r_sync1;
  logic [31:0] r_sync2;

  logic                     w_req;
  logic                     w_accept;
  logic                     w_hit_rom;
  logic                     w_hit_ram;
  logic                     w_hit_io;
  logic                     w_off_ok;
  logic                     w_err;
  logic [MEM_SIZE_LOG2-1:0] w_off;
  logic [AW-1:0]            w_idx_bus;
  logic [AW-1:0]            w_idx_mux;
  logic [31:0]              w_io_rdata;

  assign w_req     = bus_rden | bus_wren;
  assign w_accept  = (r_state == IDLE) & w_req;
  assign w_off     = bus_addr[MEM_SIZE_LOG2-1:0];
  assign w_idx_bus = bus_addr[MEM_SIZE_LOG2-1:2];

  assign w_hit_rom = (bus_addr[31:MEM_SIZE_LOG2] == ROM_BASE[31:MEM_SIZE_LOG2]);
  assign w_hit_ram = (bus_addr[31:MEM_SIZE_LOG2] == RAM_BASE[31:MEM_SIZE_LOG2]);
  assign w_hit_io  = (bus_addr[31:MEM_SIZE_LOG2] == IO_BASE[31:MEM_SIZE_LOG2]);
  assign w_off_ok  = (w_off == '0) | (w_off == MEM_SIZE_LOG2'(4));

  assign w_err = (bus_rden & bus_wren)
               | (bus_addr[1:0] != 2'b00)
               | ~(w_hit_rom | w_hit_ram | w_hit_io)
               | (w_hit_rom & bus_wren)
               | (w_hit_io & ~w_off_ok);

  // Offset 4 selects the synchronized input, offset 0 the output register.
  assign w_io_rdata = w_off[2] ? r_sync2 : r_gpio_out;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_req) w_state_nxt = (w_err | w_hit_io) ? RESP : WAIT;
      WAIT: if (r_cnt == 3'd0) w_state_nxt = RESP;
      RESP: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt      <= 3'd0;
      r_idx      <= '0;
      r_wrdata   <= 32'd0;
      r_is_wr    <= 1'b0;
      r_is_ram   <= 1'b0;
      r_err      <= 1'b0;
      r_ram_we   <= 1'b0;
      r_rddata   <= 32'd0;
      r_gpio_out <= 32'd0;
    end else if (w_accept) begin
      r_idx    <= w_idx_bus;
      r_wrdata <= bus_wrdata;
      r_is_wr  <= bus_wren;
      r_is_ram <= w_hit_ram;
      r_err    <= w_err;
      r_cnt    <= w_hit_ram ? 3'(RAM_WAIT) : 3'(ROM_WAIT);
      // The write strobe covers only the first WAIT cycle.
      r_ram_we <= ~w_err & w_hit_ram & bus_wren;
      if (w_err) begin
        r_rddata <= 32'd0;
      end else if (w_hit_io) begin
        if (bus_wren) begin
          r_rddata <= 32'd0;
          if (w_off == '0) r_gpio_out <= bus_wrdata;
        end else begin
          r_rddata <= w_io_rdata;
        end
      end
    end else begin
      r_ram_we <= 1'b0;
      if (r_state == WAIT) begin
        if (r_cnt == 3'd0) begin
          // Writes complete with zero and clear the held read value.
          r_rddata <= r_is_wr  ? 32'd0 :
                      r_is_ram ? ram_rddata : rom_rddata;
        end else begin
          r_cnt <= r_cnt - 3'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 32'd0;
      r_sync2 <= 32'd0;
    end else begin
      r_sync1 <= gpio_in;
      r_sync2 <= r_sync1;
    end
  end

  // While IDLE the memories see the incoming address so their one-cycle read
  // latency is already paid by the first WAIT cycle; this makes a zero wait
  // setting usable. Held at zero while in reset.
  assign w_idx_mux = (r_state == IDLE) ? w_idx_bus : r_idx;
  assign rom_addr  = rst ? w_idx_mux : '0;
  assign ram_addr  = rst ? w_idx_mux : '0;

  assign ram_wrdata = r_wrdata;
  assign ram_we     = r_ram_we;
  assign gpio_out   = r_gpio_out;
  assign bus_rddata = r_rddata;
  assign bus_ready  = (r_state == RESP);
  assign bus_err    = (r_state == RESP) & r_err;

endmodule

// File: tb/tb_rv32i_bus_bridge.sv
module tb_rv32i_bus_bridge;

  localparam logic [31:0] ROM_B = 32'h0040_0000;
  localparam logic [31:0] RAM_B = 32'h1001_0000;
  localparam logic [31:0] IO_B  = 32'h1002_4000;
  localparam logic [31:0] SZ    = 32'h0000_1000;
  localparam int ROMW = 0;
  localparam int RAMW = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] bus_addr, bus_wrdata, bus_rddata;
  logic        bus_wren, bus_rden, bus_ready, bus_err;
  logic [9:0]  rom_addr, ram_addr;
  logic [31:0] rom_rddata, ram_wrdata, ram_rddata;
  logic        ram_we;
  logic [31:0] gpio_out, gpio_in;

  rv32i_bus_bridge #(
    .ROM_BASE(ROM_B), .RAM_BASE(RAM_B), .IO_BASE(IO_B),
    .MEM_SIZE_LOG2(12), .ROM_WAIT(ROMW), .RAM_WAIT(RAMW)
  ) dut (
    .clk(clk), .rst(rst),
    .bus_addr(bus_addr), .bus_wrdata(bus_wrdata), .bus_wren(bus_wren), .bus_rden(bus_rden),
    .bus_rddata(bus_rddata), .bus_ready(bus_ready), .bus_err(bus_err),
    .rom_addr(rom_addr), .rom_rddata(rom_rddata),
    .ram_addr(ram_addr), .ram_wrdata(ram_wrdata), .ram_we(ram_we), .ram_rddata(ram_rddata),
    .gpio_out(gpio_out), .gpio_in(gpio_in)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] f_rom(input int i);
    return 32'h0BAD_0000 + 32'(i);
  endfunction

  function automatic logic [31:0] f_raminit(input int i);
    return 32'hA000_0000 | 32'(i);
  endfunction

  // ---------------- environment memories ----------------
  logic [31:0] rom_q = 32'd0, ram_q = 32'd0;
  logic [31:0] env_ram [1024];
  bit          env_v   [1024];
  assign rom_rddata = rom_q;
  assign ram_rddata = ram_q;

  always @(posedge clk) begin
    rom_q <= f_rom(int'(rom_addr));
    ram_q <= env_v[ram_addr] ? env_ram[ram_addr] : f_raminit(int'(ram_addr));
    if (ram_we) begin
      env_ram[ram_addr] <= ram_wrdata;
      env_v[ram_addr]   <= 1'b1;
    end
  end

  int          we_cnt = 0;
  logic [9:0]  we_addr = '0;
  always @(posedge clk) begin
    if (ram_we) begin
      we_cnt  <= we_cnt + 1;
      we_addr <= ram_addr;
    end
  end

  int cyc = 0;
  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  // ---------------- transaction-level model ----------------
  // Region code: 0 error, 1 ROM, 2 RAM, 3 GPIO.
  function automatic int f_region(input logic [31:0] a, input logic rd, input logic wr);
    logic [31:0] off;
    if (rd && wr) return 0;
    if (a[1:0] != 2'b00) return 0;
    if (a >= ROM_B && a < ROM_B + SZ) return wr ? 0 : 1;
    if (a >= RAM_B && a < RAM_B + SZ) return 2;
    if (a >= IO_B && a < IO_B + SZ) begin
      off = a - IO_B;
      return (off == 32'd0 || off == 32'd4) ? 3 : 0;
    end
    return 0;
  endfunction

  logic [31:0] m_ram  [1024];
  bit          m_ramv [1024];

  function automatic logic [31:0] f_mram(input int i);
    return m_ramv[i] ? m_ram[i] : f_raminit(i);
  endfunction

  int          mdl_region;
  int          mdl_idx;
  assign mdl_region = f_region(bus_addr, bus_rden, bus_wren);
  assign mdl_idx    = int'((bus_addr - ((bus_addr >= RAM_B) ? RAM_B : ROM_B)) >> 2) & 1023;

  bit          m_pend = 1'b0;
  int          m_free = 0;
  int          m_resp_cyc = -1;
  bit          m_err = 1'b0;
  logic [31:0] m_data = 32'd0;
  logic [31:0] m_gpio = 32'd0;
  logic [31:0] m_held = 32'd0;
  int          m_we_cyc = -1;
  int          m_we_idx = 0;
  logic [31:0] m_we_dat = 32'd0;
  bit          m_wpend = 1'b0;
  int          m_wcyc = -1;

  // Edge number of the current rising edge is cyc+1; a response expected
  // with latency L after an accept at edge e is observed in cycle e+L-1, and
  // the next accept is possible at edge e+L+1.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_pend   <= 1'b0;
      m_free   <= 0;
      m_gpio   <= 32'd0;
      m_we_cyc <= -1;
      m_wpend  <= 1'b0;
    end else begin
      if (m_wpend && cyc + 1 == m_wcyc) begin
        m_ram[m_we_idx]  <= m_we_dat;
        m_ramv[m_we_idx] <= 1'b1;
        m_wpend          <= 1'b0;
      end
      if ((bus_rden || bus_wren) && cyc + 1 >= m_free) begin
        m_pend <= 1'b1;
        m_err  <= (mdl_region == 0);
        case (mdl_region)
          1: begin
            m_data     <= f_rom(mdl_idx);
            m_resp_cyc <= cyc + 2 + ROMW;
            m_free     <= cyc + 4 + ROMW;
          end
          2: begin
            m_data     <= bus_wren ? 32'd0 : f_mram(mdl_idx);
            m_resp_cyc <= cyc + 2 + RAMW;
            m_free     <= cyc + 4 + RAMW;
            if (bus_wren) begin
              m_we_cyc <= cyc + 1;
              m_we_idx <= mdl_idx;
              m_we_dat <= bus_wrdata;
              m_wpend  <= 1'b1;
              m_wcyc   <= cyc + 2;
            end
          end
          3: begin
            m_resp_cyc <= cyc + 1;
            m_free     <= cyc + 3;
            if (bus_wren) begin
              m_data <= 32'd0;
              if (bus_addr == IO_B) m_gpio <= bus_wrdata;
            end else begin
              m_data <= (bus_addr == IO_B) ? m_gpio : gpio_in;
            end
          end
          default: begin
            m_data     <= 32'd0;
            m_resp_cyc <= cyc + 1;
            m_free     <= cyc + 3;
          end
        endcase
      end
    end
  end

  bit run_cmp = 1'b0;

  always @(negedge clk or negedge rst) begin
    if (!rst) begin
      m_held <= 32'd0;
    end else if (run_cmp) begin
      check("cmp_bus_ready", 32'(bus_ready), 32'(m_pend && cyc == m_resp_cyc));
      check("cmp_bus_err", 32'(bus_err), 32'(m_pend && cyc == m_resp_cyc && m_err));
      check("cmp_bus_rddata", bus_rddata, (m_pend && cyc == m_resp_cyc) ? m_data : m_held);
      if (m_pend && cyc == m_resp_cyc) m_held <= m_data;
      check("cmp_ram_we", 32'(ram_we), 32'(cyc == m_we_cyc));
      if (cyc == m_we_cyc) begin
        check("cmp_ram_addr", 32'(ram_addr), 32'(m_we_idx));
        check("cmp_ram_wrdata", ram_wrdata, m_we_dat);
      end
      check("cmp_gpio_out", gpio_out, m_gpio);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic xact(input logic [31:0] a, input logic [31:0] d, input logic rd, input logic wr,
                      output logic [31:0] got, output logic gerr, output int lat);
    int i;
    bit seen;
    @(negedge clk);
    bus_addr = a; bus_wrdata = d; bus_rden = rd; bus_wren = wr;
    @(posedge clk);
    #1;
    bus_rden = 1'b0; bus_wren = 1'b0;
    lat = 0; got = 32'd0; gerr = 1'b0; seen = 1'b0; i = 0;
    while (!seen && i < 20) begin
      @(negedge clk);
      i++;
      if (bus_ready) begin
        seen = 1'b1; lat = i; got = bus_rddata; gerr = bus_err;
      end
    end
    @(posedge clk);
  endtask

  logic [31:0] err_addr [5] = '{32'h0040_0004, 32'h1001_0002, 32'h2000_0000, 32'h1001_0000, 32'h1002_4008};
  logic        err_rd   [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  logic        err_wr   [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

  logic [31:0] got;
  logic        gerr;
  int          lat;
  int          nrdy, first_rdy, second_rdy;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    bus_addr = 32'd0; bus_wrdata = 32'd0; bus_rden = 1'b0; bus_wren = 1'b0;
    gpio_in = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_bus_ready", 32'(bus_ready), 32'd0);
    check("rst_bus_err", 32'(bus_err), 32'd0);
    check("rst_bus_rddata", bus_rddata, 32'd0);
    check("rst_ram_we", 32'(ram_we), 32'd0);
    check("rst_gpio_out", gpio_out, 32'd0);
    check("rst_rom_addr", 32'(rom_addr), 32'd0);
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    run_cmp = 1'b1;

    // RAM write then read back
    xact(32'h1001_0010, 32'hDEAD_BEEF, 1'b0, 1'b1, got, gerr, lat);
    check("ramwr_lat", 32'(lat), 32'd3);
    check("ramwr_err", 32'(gerr), 32'd0);
    check("ramwr_data", got, 32'd0);
    check("ramwr_we_count", 32'(we_cnt), 32'd1);
    check("ramwr_we_addr", 32'(we_addr), 32'd4);
    xact(32'h1001_0010, 32'd0, 1'b1, 1'b0, got, gerr, lat);
    check("ramrd_lat", 32'(lat), 32'd3);
    check("ramrd_data", got, 32'hDEAD_BEEF);

    // ROM reads with zero wait
    xact(32'h0040_0000, 32'd0, 1'b1, 1'b0, got, gerr, lat);
    check("romrd0_lat", 32'(lat), 32'd2);
    check("romrd0_data", got, 32'h0BAD_0000);
    xact(32'h0040_0008, 32'd0, 1'b1, 1'b0, got, gerr, lat);
    check("romrd2_data", got, 32'h0BAD_0002);

    // GPIO
    xact(IO_B, 32'h0000_00A5, 1'b0, 1'b1, got, gerr, lat);
    check("gpiowr_lat", 32'(lat), 32'd1);
    check("gpiowr_out", gpio_out, 32'h0000_00A5);
    xact(IO_B, 32'd0, 1'b1, 1'b0, got, gerr, lat);
    check("gpiord0_data", got, 32'h0000_00A5);
    gpio_in = 32'h0000_1234;
    repeat (3) @(negedge clk);
    xact(IO_B + 32'd4, 32'd0, 1'b1, 1'b0, got, gerr, lat);
    check("gpiord4_lat", 32'(lat), 32'd1);
    check("gpiord4_data", got, 32'h0000_1234);
    repeat (2) @(negedge clk);
    check("rddata_held", bus_rddata, 32'h0000_1234);

    // Error cases
    for (int k = 0; k < 5; k++) begin
      xact(err_addr[k], 32'hFFFF_FFFF, err_rd[k], err_wr[k], got, gerr, lat);
      check("err_lat", 32'(lat), 32'd1);
      check("err_flag", 32'(gerr), 32'd1);
      check("err_data", got, 32'd0);
    end
    check("err_no_we", 32'(we_cnt), 32'd1);
    check("err_gpio_kept", gpio_out, 32'h0000_00A5);

    // Reset during the first WAIT cycle of a RAM write
    @(negedge clk);
    bus_addr = 32'h1001_0020; bus_wrdata = 32'hCAFE_F00D; bus_wren = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    bus_wren = 1'b0;
    #1;
    check("midrst_ready", 32'(bus_ready), 32'd0);
    check("midrst_ram_we", 32'(ram_we), 32'd0);
    check("midrst_gpio", gpio_out, 32'd0);
    check("midrst_rddata", bus_rddata, 32'd0);
    check("midrst_ram_addr", 32'(ram_addr), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    check("midrst_no_we", 32'(we_cnt), 32'd1);
    xact(32'h1001_0020, 32'd0, 1'b1, 1'b0, got, gerr, lat);
    check("postrst_lat", 32'(lat), 32'd3);
    check("postrst_data", got, 32'hA000_0008);

    // Request held through RESP: serviced twice with an IDLE cycle between
    @(negedge clk);
    bus_addr = 32'h1001_0010; bus_rden = 1'b1;
    nrdy = 0; first_rdy = 0; second_rdy = 0;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      if (bus_ready) begin
        nrdy++;
        if (first_rdy == 0) first_rdy = i;
        else second_rdy = i;
        check("held_req_data", bus_rddata, 32'hDEAD_BEEF);
      end
    end
    bus_rden = 1'b0;
    check("held_req_count", 32'(nrdy), 32'd2);
    check("held_req_first", 32'(first_rdy), 32'd3);
    check("held_req_second", 32'(second_rdy), 32'd7);
    repeat (4) @(negedge clk);

    run_cmp = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
